// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter
//
// Shares one word-wide memory read port between the I-cache and D-cache
// refill engines. A requester asks for a whole line by base address; the
// arbiter grants one side round-robin, issues LINE_WORDS consecutive word
// reads on the mem_req/mem_ready handshake and streams each returned word
// back to the winner tagged with its index within the line.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_addr                I-cache line request and line address
//   i_gnt                       I side owns memory (grant through done)
//   i_rdata/i_rvalid/i_word     returned word, one-cycle valid, word index
//   i_done                      pulses with the last i_rvalid of a line
//   d_*                         identical set for the D-cache
//   mem_addr/mem_req            word-aligned read address and request
//   mem_rdata/mem_ready         read data and beat completion
module line_fill_arbiter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic                          i_gnt,
    output logic [31:0]                   i_rdata,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] i_word,
    output logic                          i_done,

    input  logic                          d_req,
    input  logic [31:0]                   d_addr,
    output logic                          d_gnt,
    output logic [31:0]                   d_rdata,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_WORDS)-1:0] d_word,
    output logic                          d_done,

    output logic [31:0]                   mem_addr,
    output logic                          mem_req,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ready
);

    localparam int unsigned WordW   = $clog2(LINE_WORDS);
    localparam int unsigned AddrLsb = WordW + 2;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    // Side encoding for owner/last: 0 = I, 1 = D.
    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [31:AddrLsb]     base_q, base_d;
    logic [WordW-1:0]      cnt_q, cnt_d;
    logic                  i_gnt_q, i_gnt_d;
    logic                  d_gnt_q, d_gnt_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [WordW-1:0]      word_q, word_d;
    logic                  i_rvalid_q, i_rvalid_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  win;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        i_gnt_d    = i_gnt_q;
        d_gnt_d    = d_gnt_q;
        mem_req_d  = mem_req_q;
        rdata_d    = rdata_q;
        word_d     = word_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        // On a tie the side that was not served last wins.
        win        = (i_req && d_req) ? ~last_q : d_req;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d   = win;
                    last_d    = win;
                    base_d    = win ? d_addr[31:AddrLsb] : i_addr[31:AddrLsb];
                    cnt_d     = '0;
                    i_gnt_d   = ~win;
                    d_gnt_d   = win;
                    mem_req_d = 1'b1;
                    state_d   = StFill;
                end
            end
            StFill: begin
                // mem_req_q is high for the whole fill, so mem_ready alone marks a beat.
                if (mem_ready) begin
                    rdata_d    = mem_rdata;
                    word_d     = cnt_q;
                    i_rvalid_d = ~owner_q;
                    d_rvalid_d = owner_q;
                    cnt_d      = cnt_q + WordW'(1);
                    if (cnt_q == WordW'(LINE_WORDS - 1)) begin
                        cnt_d     = '0;
                        i_done_d  = ~owner_q;
                        d_done_d  = owner_q;
                        mem_req_d = 1'b0;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                // Grant drops here; requests are not looked at until IDLE.
                i_gnt_d = 1'b0;
                d_gnt_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                i_gnt_d   = 1'b0;
                d_gnt_d   = 1'b0;
                mem_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            base_q     <= '0;
            cnt_q      <= '0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            rdata_q    <= '0;
            word_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            mem_req_q  <= mem_req_d;
            rdata_q    <= rdata_d;
            word_q     <= word_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
        end
    end

    // Data and index are shared; each side only sees them while its valid is up.
    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign i_rdata  = i_rvalid_q ? rdata_q : '0;
    assign d_rdata  = d_rvalid_q ? rdata_q : '0;
    assign i_word   = i_rvalid_q ? word_q : '0;
    assign d_word   = d_rvalid_q ? word_q : '0;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_req_q ? {base_q, cnt_q, 2'b00} : '0;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Self-checking bench for line_fill_arbiter: randomized memory data, ready
// patterns and line addresses checked cycle by cycle against a line-level
// reference model (expected address = base + 4*k, one valid per beat,
// round-robin winner derived from the arbitration rules).
module tb_line_fill_arbiter;

    localparam int unsigned LW = 4;
    localparam int unsigned WW = $clog2(LW);

    logic          clk;
    logic          rst_n;
    logic          i_req, d_req;
    logic [31:0]   i_addr, d_addr;
    logic          i_gnt, d_gnt;
    logic [31:0]   i_rdata, d_rdata;
    logic          i_rvalid, d_rvalid;
    logic [WW-1:0] i_word, d_word;
    logic          i_done, d_done;
    logic [31:0]   mem_addr;
    logic          mem_req;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    int tests_run    = 0;
    int tests_failed = 0;
    bit tb_last;          // model of the round-robin pointer, 1 = D
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    line_fill_arbiter #(.LINE_WORDS(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_word    (i_word),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_word    (d_word),
        .d_done    (d_done),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit pick(input bit ir, input bit dr, input bit last);
        if (ir && dr) return ~last;
        return dr;
    endfunction

    // Caller raises the winner's req at a negedge; the next posedge is the
    // grant edge T. Returns at the negedge of cycle L+2 (back in IDLE).
    task automatic run_fill(input bit side, input logic [31:0] addr, input int mode,
                            input bit drop, input int raise_at);
        logic [31:0]      base;
        int               k;
        int               cyc;
        int               pidx;
        bit               prev_beat;
        bit               fin;
        bit               raised;
        bit               rdy;
        logic [31:0]      prev_data;
        logic [2:0]       got_ctl, exp_ctl;
        logic [1:0]       got_vd, exp_vd;
        logic [WW+31:0]   got_wd, exp_wd;
        logic [WW+33:0]   oth;
        base      = addr & ~(32'(LW * 4) - 32'd1);
        k         = 0;
        cyc       = 0;
        pidx      = 0;
        prev_beat = 1'b0;
        fin       = 1'b0;
        raised    = 1'b0;
        prev_data = '0;
        @(negedge clk);
        while (!fin && cyc < 64) begin
            got_ctl = {i_gnt, d_gnt, mem_req};
            exp_ctl = {~side, side, (k < LW)};
            tests_run++;
            if (got_ctl !== exp_ctl) begin
                tests_failed++;
                $display("FAIL ctl cyc%0d: gnt_i/gnt_d/req got %b expected %b", cyc, got_ctl,
                         exp_ctl);
            end
            if (k < LW) begin
                tests_run++;
                if (mem_addr !== base + 32'(k * 4)) begin
                    tests_failed++;
                    $display("FAIL mem_addr cyc%0d: got %h expected %h", cyc, mem_addr,
                             base + 32'(k * 4));
                end
            end
            got_vd = side ? {d_rvalid, d_done} : {i_rvalid, i_done};
            exp_vd = {prev_beat, prev_beat && (k == LW)};
            tests_run++;
            if (got_vd !== exp_vd) begin
                tests_failed++;
                $display("FAIL rvalid/done cyc%0d: got %b expected %b", cyc, got_vd, exp_vd);
            end
            if (prev_beat) begin
                got_wd = side ? {d_word, d_rdata} : {i_word, i_rdata};
                exp_wd = {WW'(k - 1), prev_data};
                tests_run++;
                if (got_wd !== exp_wd) begin
                    tests_failed++;
                    $display("FAIL word/rdata cyc%0d: got %h expected %h", cyc, got_wd, exp_wd);
                end
            end
            oth = side ? {i_rvalid, i_done, i_word, i_rdata} : {d_rvalid, d_done, d_word, d_rdata};
            tests_run++;
            if (oth !== '0) begin
                tests_failed++;
                $display("FAIL idle side cyc%0d: got %h expected 0", cyc, oth);
            end
            if (prev_beat && k == LW) begin
                fin = 1'b1;
            end else begin
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = (pidx < 7) ? pat[pidx] : 1'b1;
                else                rdy = 1'($urandom % 2);
                pidx++;
                mem_ready = rdy;
                mem_rdata = $urandom;
                prev_beat = rdy;
                if (rdy) begin
                    prev_data = mem_rdata;
                    k++;
                end
                if (drop && cyc == 0) begin
                    if (side) begin d_req = 1'b0; d_addr = $urandom; end
                    else      begin i_req = 1'b0; i_addr = $urandom; end
                end
                if (!raised && k == raise_at) begin
                    raised = 1'b1;
                    if (side) i_req = 1'b1;
                    else      d_req = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        if (!fin) begin
            tests_run++;
            tests_failed++;
            $display("FAIL fill timeout: got %0d beats expected %0d", k, LW);
        end
        tests_run++;
        if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
            tests_failed++;
            $display("FAIL post-done idle: got %b expected 000", {i_gnt, d_gnt, mem_req});
        end
        mem_ready = 1'b1;
        tb_last   = side;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({i_gnt, i_rdata, i_rvalid, i_word, i_done, d_gnt, d_rdata, d_rvalid, d_word, d_done,
             mem_addr, mem_req} !== '0) begin
            tests_failed++;
            $display("FAIL reset outputs: got nonzero expected all 0");
        end
        tb_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; mem_ready = 1; mem_rdata = 0;
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        tests_run++;
        if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle after reset: got %b expected 000", {i_gnt, d_gnt, mem_req});
        end
    endtask

    task automatic test_single_i();
        i_addr = 32'h0000_1234;
        i_req  = 1'b1;
        run_fill(pick(1, 0, tb_last), i_addr, 0, 0, -1);
        i_req = 1'b0;
    endtask

    task automatic test_round_robin();
        bit w;
        apply_reset();
        i_addr = $urandom; d_addr = $urandom;
        i_req = 1'b1; d_req = 1'b1;
        w = pick(1, 1, tb_last);
        run_fill(w, w ? d_addr : i_addr, 2, 0, -1);
        // Both keep requesting: the other side must be served next.
        w = pick(1, 1, tb_last);
        run_fill(w, w ? d_addr : i_addr, 2, 0, -1);
        if (w) d_req = 1'b0; else i_req = 1'b0;
        w = pick(i_req, d_req, tb_last);
        run_fill(w, w ? d_addr : i_addr, 0, 0, -1);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_wait_states();
        i_addr = $urandom;
        i_req  = 1'b1;
        run_fill(pick(1, 0, tb_last), i_addr, 1, 0, -1);
        i_req = 1'b0;
    endtask

    task automatic test_drop_req();
        logic [31:0] a;
        a = $urandom;
        d_addr = a;
        d_req  = 1'b1;
        run_fill(pick(0, 1, tb_last), a, 2, 1, -1);
        d_req = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        d_addr = $urandom;
        d_req  = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            mem_rdata = $urandom;
        end
        tests_run++;
        if ({d_gnt, mem_req, d_rvalid} !== 3'b111) begin
            tests_failed++;
            $display("FAIL pre-abort: got %b expected 111", {d_gnt, mem_req, d_rvalid});
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, d_gnt, d_rvalid, mem_addr} !== '0) begin
            tests_failed++;
            $display("FAIL async abort: got %b expected 0", {mem_req, d_gnt, d_rvalid});
        end
        tb_last = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        d_addr = $urandom;
        run_fill(pick(0, 1, tb_last), d_addr, 0, 0, -1);
        d_req = 1'b0;
    endtask

    task automatic test_mid_fill_arrival();
        bit w;
        d_addr = $urandom; i_addr = $urandom;
        d_req  = 1'b1;
        run_fill(pick(0, 1, tb_last), d_addr, 2, 0, 2);
        w = pick(i_req, d_req, tb_last);
        run_fill(w, w ? d_addr : i_addr, 0, 0, -1);
        i_req = 1'b0;
        w = pick(i_req, d_req, tb_last);
        run_fill(w, w ? d_addr : i_addr, 2, 0, -1);
        d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit w;
        for (int n = 0; n < 6; n++) begin
            i_addr = $urandom; d_addr = $urandom;
            i_req  = 1'($urandom % 2);
            d_req  = ~i_req | 1'($urandom % 2);
            w = pick(i_req, d_req, tb_last);
            run_fill(w, w ? d_addr : i_addr, 2, 0, -1);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_i();
        test_wait_states();
        test_drop_req();
        test_reset_mid_fill();
        test_mid_fill_arrival();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
